// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
//   Shares a single i2c_master between NUM_REQ independent clients. A
//   round-robin search picks one pending client at a time. The arbiter
//   latches that client's command onto the master inputs and pulses the
//   master's write or read enable for one cycle. It then waits for the
//   master to finish, or for the timeout to expire, and returns the read
//   data and status to the granted client. A programmable idle gap is
//   inserted before the next grant.
//
// Ports
//   clk, reset        system clock, synchronous active-low reset
//   req_valid         per-client request, held by the client until req_accept
//   req_read          per-client direction (1 = read, 0 = write)
//   req_chip_addr     7 bits per client, client i at [7i+6:7i]
//   req_reg_addr      8 bits per client, client i at [8i+7:8i]
//   req_wdata         8 bits per client, client i at [8i+7:8i]
//   req_accept        one-cycle pulse to the winner when its command is latched
//   rsp_done          one-cycle pulse to the owner when the transaction ends
//   rsp_data          read data (0 on timeout), held between pulses
//   rsp_status        master status captured with rsp_done, held between pulses
//   rsp_timeout       pulses together with rsp_done when the wait was aborted
//   m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
//                     command interface to the i2c_master
//   m_done, m_busy, m_data_out, m_status
//                     completion interface from the i2c_master
module i2c_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TXN_GAP = 0,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_read,
  input  logic [7*NUM_REQ-1:0]   req_chip_addr,
  input  logic [8*NUM_REQ-1:0]   req_reg_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_accept,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [7:0]             rsp_data,
  output logic [2:0]             rsp_status,
  output logic                   rsp_timeout,
  output logic [6:0]             m_chip_addr,
  output logic [7:0]             m_reg_addr,
  output logic [7:0]             m_data_in,
  output logic                   m_write_en,
  output logic                   m_read_en,
  input  logic                   m_done,
  input  logic                   m_busy,
  input  logic [7:0]             m_data_out,
  input  logic [2:0]             m_status
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PTR_INIT = PW'(NUM_REQ - 1);
  // Final count values: the gap lasts max(TXN_GAP,1) cycles, and the
  // timeout fires on the TIMEOUT-th cycle spent waiting.
  localparam logic [15:0] GAP_LAST = (TXN_GAP > 1) ? 16'(TXN_GAP - 1) : 16'd0;
  localparam logic [15:0] TO_LAST  = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;   // last winner; also the owner of the transaction in flight
  logic [15:0]   cnt;      // shared by the wait timeout and the idle gap

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic [6:0]    win_chip;
  logic [7:0]    win_reg;
  logic [7:0]    win_wdata;
  logic          win_read;

  // Round-robin search that starts just after the last winner and wraps.
  // The command fields of the winner are then picked out of the flat buses.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_chip  = '0;
    win_reg   = '0;
    win_wdata = '0;
    win_read  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_chip  = req_chip_addr[7*i +: 7];
        win_reg   = req_reg_addr[8*i +: 8];
        win_wdata = req_wdata[8*i +: 8];
        win_read  = req_read[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= PTR_INIT;
      cnt         <= '0;
      req_accept  <= '0;
      rsp_done    <= '0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data_in   <= '0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
    end else begin
      req_accept  <= '0;
      rsp_done    <= '0;
      rsp_timeout <= 1'b0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
      case (state)
        S_IDLE: begin
          // The enable is raised together with the accept, so it is high
          // exactly for the single cycle spent in S_ISSUE.
          if (win_found && !m_busy) begin
            req_accept  <= NUM_REQ'(1) << win_idx;
            m_chip_addr <= win_chip;
            m_reg_addr  <= win_reg;
            m_data_in   <= win_wdata;
            m_write_en  <= !win_read;
            m_read_en   <= win_read;
            rr_ptr      <= win_idx;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // m_done is deliberately not looked at here.
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the same cycle as the timeout wins.
          if (m_done) begin
            rsp_done   <= NUM_REQ'(1) << rr_ptr;
            rsp_data   <= m_data_out;
            rsp_status <= m_status;
            cnt        <= '0;
            state      <= S_GAP;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            rsp_done    <= NUM_REQ'(1) << rr_ptr;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            rsp_status  <= m_status;
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter
//   Randomized bench for i2c_bus_arbiter with three clients, a 5-cycle
//   transaction gap and a 100-cycle timeout. A behavioural i2c_master
//   answers each command and queues the response it expects back. A
//   monitor predicts grants from the round-robin rule and compares every
//   cycle. It pops the response queue whenever rsp_done pulses.
module tb_i2c_bus_arbiter;

  localparam int N    = 3;
  localparam int GAP  = 5;
  localparam int TO   = 100;
  localparam int GLEN = (GAP == 0) ? 1 : GAP;
  localparam int NCYC = 3800;
  localparam int NEVER = 1 << 30;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid, req_read;
  logic [7*N-1:0] req_chip_addr;
  logic [8*N-1:0] req_reg_addr, req_wdata;
  logic [N-1:0]   req_accept, rsp_done;
  logic [7:0]     rsp_data;
  logic [2:0]     rsp_status;
  logic           rsp_timeout;
  logic [6:0]     m_chip_addr;
  logic [7:0]     m_reg_addr, m_data_in;
  logic           m_write_en, m_read_en;
  logic           m_done, m_busy;
  logic [7:0]     m_data_out;
  logic [2:0]     m_status;

  i2c_bus_arbiter #(.NUM_REQ(N), .TXN_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_read(req_read),
    .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .rsp_done(rsp_done), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_done(m_done), .m_busy(m_busy), .m_data_out(m_data_out), .m_status(m_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] status;
    logic       to;
    int         at;
  } rsp_t;

  rsp_t rq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   txn_no = 0;
  bit   rst_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // Driver: clients, reset and the behavioural i2c_master.
  initial begin
    bit prev_rst, m_act, drops_on, spur_on, force_a5;
    int p_req, mode, m_mode, m_issue, m_done_at, m_busy_end, m_end, len;
    reset = 1'b0; req_valid = '0; req_read = '0;
    req_chip_addr = '0; req_reg_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_busy = 1'b0; m_data_out = '0; m_status = '0;
    m_act = 0; m_mode = 0; m_issue = 0; m_done_at = -1; m_busy_end = 0; m_end = 0;
    force_a5 = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      prev_rst = reset;
      p_req    = (cyc < 100) ? 0 : (cyc < 800) ? 100 : (cyc < 3000) ? 30 : (cyc < 3500) ? 50 : 0;
      drops_on = (cyc >= 800 && cyc < 3000);
      spur_on  = drops_on;

      if (cyc < 5) begin
        reset = 1'b0;
      end else if (!rst_done && cyc >= 3000 && m_act && m_mode == 1 && cyc == m_issue + 10) begin
        reset = 1'b0;
        rst_done = 1;
      end else begin
        reset = 1'b1;
      end

      if (!prev_rst) begin
        m_act = 0; m_done = 1'b0; m_busy = 1'b0;
      end else begin
        m_done = 1'b0;
        if (!m_act) begin
          m_data_out = 8'($urandom);
          m_status   = 3'($urandom);
          if (m_write_en || m_read_en) begin
            if (cyc >= 800 && cyc < 3000) begin
              len  = int'($urandom_range(0, 19));
              mode = (len < 3) ? len + 1 : 0;
            end else begin
              mode = (cyc >= 3000 && !rst_done) ? 1 : 0;
            end
            m_act = 1; m_mode = mode; m_issue = cyc;
            case (mode)
              1: begin m_done_at = -1;       m_busy_end = cyc + TO + int'($urandom_range(0, 4)); end
              2: begin m_done_at = cyc + TO; m_busy_end = cyc + TO - 1; end
              3: begin m_done_at = cyc + TO + 1; m_busy_end = cyc + TO + 1; end
              default: begin
                len = int'($urandom_range(1, 6));
                m_done_at  = cyc + len;
                m_busy_end = cyc + len - 1 + (spur_on ? int'($urandom_range(0, 10)) : 0);
              end
            endcase
            m_end = (m_done_at > m_busy_end) ? m_done_at : m_busy_end;
            if (force_a5) begin
              m_data_out = 8'hA5; m_status = 3'd0; force_a5 = 0;
            end
            if (spur_on && $urandom_range(0, 3) == 0) m_done = 1'b1;
            if (m_done_at > 0 && m_done_at - cyc <= TO)
              rq.push_back('{m_data_out, m_status, 1'b0, m_done_at + 1});
            else
              rq.push_back('{8'h00, m_status, 1'b1, cyc + TO + 1});
          end else if (spur_on && $urandom_range(0, 9) == 0) begin
            m_done = 1'b1;
          end
        end
        if (m_act) begin
          if (cyc == m_done_at) m_done = 1'b1;
          m_busy = (cyc > m_issue) && (cyc <= m_busy_end);
          if (cyc >= m_end) m_act = 0;
        end else begin
          m_busy = 1'b0;
        end
      end

      for (int i = 0; i < N; i++) begin
        if (req_accept[i]) begin
          req_valid[i] = 1'b0;
          txn_no++;
        end else if (req_valid[i]) begin
          if (drops_on && $urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
        end else if (int'($urandom_range(0, 99)) < p_req) begin
          req_valid[i] = 1'b1;
          req_read[i]  = 1'($urandom);
          req_chip_addr[7*i +: 7] = 7'($urandom);
          req_reg_addr[8*i +: 8]  = 8'($urandom);
          req_wdata[8*i +: 8]     = 8'($urandom);
        end
      end
      if (cyc == 6) begin
        req_valid[0] = 1'b1; req_read[0] = 1'b0;
        req_chip_addr[6:0] = 7'h39; req_reg_addr[7:0] = 8'h41; req_wdata[7:0] = 8'h00;
      end
      if (cyc == 60) begin
        req_valid[1] = 1'b1; req_read[1] = 1'b1;
        req_chip_addr[13:7] = 7'h3C; req_reg_addr[15:8] = 8'h0A; req_wdata[15:8] = 8'h00;
        force_a5 = 1;
      end
    end
    chk("rsp_queue_empty", rq.size(), 0);
    chk("reset_in_wait_seen", {31'd0, rst_done}, 1);
    chk("enough_transactions", {31'd0, txn_no >= 40}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: compares every cycle, predicts the next cycle from the rules.
  initial begin
    logic [N-1:0] exp_acc;
    logic         exp_we, exp_re;
    logic [6:0]   e_chip;
    logic [7:0]   e_reg, e_wd, e_data;
    logic [2:0]   e_stat;
    int           last, owner, avail, w;
    rsp_t         e;
    exp_acc = '0; exp_we = 1'b0; exp_re = 1'b0;
    e_chip = '0; e_reg = '0; e_wd = '0; e_data = '0; e_stat = '0;
    last = N - 1; owner = 0; avail = NEVER;
    forever begin
      @(negedge clk);
      chk("req_accept", req_accept, exp_acc);
      chk("m_write_en", m_write_en, exp_we);
      chk("m_read_en", m_read_en, exp_re);
      chk("m_chip_addr", m_chip_addr, e_chip);
      chk("m_reg_addr", m_reg_addr, e_reg);
      chk("m_data_in", m_data_in, e_wd);
      if (rsp_done != '0) begin
        if (rq.size() == 0) begin
          chk("rsp_done_unexpected", rsp_done, 0);
        end else begin
          e = rq.pop_front();
          chk("rsp_cycle", cyc, e.at);
          chk("rsp_done_owner", rsp_done, N'(1) << owner);
          chk("rsp_timeout", rsp_timeout, e.to);
          e_data = e.data;
          e_stat = e.status;
        end
        avail = cyc + GLEN;
      end else begin
        chk("rsp_timeout_idle", rsp_timeout, 0);
        if (rq.size() != 0 && rq[0].at <= cyc) begin
          checks++;
          failures++;
          $display("FAIL rsp_missing cyc=%0d actual=no_rsp_done expected_at=%0d", cyc, rq[0].at);
          void'(rq.pop_front());
          avail = cyc + GLEN;
        end
      end
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_status", rsp_status, e_stat);

      exp_acc = '0; exp_we = 1'b0; exp_re = 1'b0;
      if (reset == 1'b0) begin
        last = N - 1; avail = cyc + 1;
        e_chip = '0; e_reg = '0; e_wd = '0; e_data = '0; e_stat = '0;
        rq.delete();
      end else if (cyc >= avail && req_valid != '0 && !m_busy) begin
        w = rr_pick(last, req_valid);
        exp_acc = N'(1) << w;
        e_chip  = 7'(req_chip_addr >> (7 * w));
        e_reg   = 8'(req_reg_addr >> (8 * w));
        e_wd    = 8'(req_wdata >> (8 * w));
        exp_re  = 1'((req_read >> w) & 1);
        exp_we  = !exp_re;
        owner = w; last = w; avail = NEVER;
      end
    end
  end

endmodule
